debounce_bank: RTL and testbench
================================

// Module: debounce_bank
// PURPOSE
//  Multi-channel push-button conditioner: one shared slow-tick prescaler plus N per-channel
//  synchroniser/debounce state machines.
//  Produces clean levels and one-cycle rise/fall pulses for the VGA controller's user inputs.
//  Successor to the single fixed-divide debounce enable: divide ratio, channel count, stability
//  window and input polarity are all parametrised.
// PARAMETERS
//  N_CH          4            number of button channels
//  CLK_HZ        100_000_000  Clk_100M frequency
//  TICK_HZ       400          debounce sample rate; DIV = CLK_HZ/TICK_HZ (default 250000), DIV >= 2
//  STABLE_TICKS  4            consecutive mismatching ticks required to accept a new level (>= 1)
//  SYNC_STAGES   2            metastability flops per channel (>= 2)
//  ACTIVE_LOW_IN 0            1: raw input inverted before synchroniser (pressed = 0 on pin)
//  RPT_DELAY     200          ticks held before first repeat (DEBOUNCE_REPEAT_EN only)
//  RPT_PERIOD    40           ticks between repeats (DEBOUNCE_REPEAT_EN only)
// PORTS
//  Clk_100M   in   1     system clock; single clock domain
//  Rst_n      in   1     synchronous, active-low reset
//  btn_raw    in   N_CH  asynchronous raw button pins
//  tick_en    out  1     one-cycle pulse every DIV clocks
//  btn_level  out  N_CH  debounced level, 1 = pressed
//  btn_rise   out  N_CH  one-cycle pulse on accepted press
//  btn_fall   out  N_CH  one-cycle pulse on accepted release
//  btn_rpt    out  N_CH  auto-repeat pulses (present only with DEBOUNCE_REPEAT_EN)
// BEHAVIOUR
//  Reset: Rst_n sampled on Clk_100M. While low, the next edge clears:
//   - prescaler, sync flops, channel counters;
//   - all outputs (btn_level, pulses, tick_en) to 0.
//  Reset mid-debounce discards the partial count. No output glitch on exit.
//  Prescaler: cnt 0..DIV-1, wraps to 0. tick_en = registered (cnt == DIV-1).
//   First tick_en is DIV cycles after reset release.
//  Sync: s = last stage of SYNC_STAGES flop chain on (btn_raw ^ ACTIVE_LOW_IN).
//  Channel FSM states:
//   STABLE: s == btn_level; cnt_ch held at 0.
//   PEND:   s != btn_level.
//    - Each tick_en in PEND increments cnt_ch.
//    - On tick_en with cnt_ch == STABLE_TICKS-1: btn_level <= s, cnt_ch <= 0, -> STABLE.
//      btn_rise or btn_fall is asserted for that same single cycle.
//    - s returning to btn_level at any cycle -> STABLE, cnt_ch <= 0 (bounce restarts window).
//  Latency: level/pulse update on the STABLE_TICKS-th tick_en after s first differs.
//   Worst case SYNC_STAGES + STABLE_TICKS*DIV cycles.
//  Simultaneous: tick_en and s toggling back in the same cycle -> no acceptance, count cleared.
//   Channels are fully independent; several may pulse in the same cycle.
//  Width: cnt_ch = $clog2(STABLE_TICKS+1) bits, saturating is unnecessary by construction.
//   Prescaler width = $clog2(DIV).
// CONFIGURATION
//  DEBOUNCE_REPEAT_EN defined:
//   - btn_rpt port and per-channel repeat counter exist.
//   - While btn_level == 1: first btn_rpt pulse on the RPT_DELAY-th tick after btn_rise,
//     then every RPT_PERIOD ticks.
//   - Release or reset clears the counter immediately; btn_rpt never coincides with btn_rise.
//  Undefined: no btn_rpt port, no repeat logic; all other behaviour identical.
// STRUCTURE
//  debounce_pkg:
//   - typedef enum logic {ST_STABLE, ST_PEND} db_state_t;
//   - function div_calc(clk_hz, tick_hz);
//   - localparam width helpers.
//  Sub-module tick_gen (prescaler, params DIV) instantiated once.
//  Channels are a generate loop in debounce_bank.
// TESTING (sim params: CLK_HZ=1000, TICK_HZ=100 -> DIV=10, STABLE_TICKS=3, RPT_DELAY=5, RPT_PERIOD=2)
//  1 Reset release, btn_raw=0 -> tick_en first at cycle 10, then every 10; all btn_* stay 0.
//  2 ch0 raw 0->1 held -> btn_level[0]=1 with btn_rise[0] single pulse on 3rd tick after sync; btn_fall never.
//  3 ch1 raw toggled 1 tick-period after press (bounce), then stable -> no pulse until 3 full ticks of stability.
//  4 ch0 and ch2 press same cycle -> rise pulses same cycle; release ch0 -> only btn_fall[0].
//  5 Rst_n low for 1 cycle mid-PEND (2 ticks counted) -> count cleared; acceptance needs 3 fresh ticks.
//  6 REPEAT_EN, ch3 held -> btn_rpt[3] at ticks 5,7,9 after rise; release stops it; ACTIVE_LOW_IN=1 inverts sense.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and elaboration-time helpers for the push-button debounce bank.
package debounce_pkg;

    typedef enum logic {ST_STABLE, ST_PEND} db_state_t;

    function automatic int div_calc(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    // Bits needed to hold any value in 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_bank_tick_gen.sv
// Shared slow-tick prescaler: counts 0..DIV-1 and emits a registered one-cycle tick_en.
module tick_gen
    import debounce_pkg::*;
#(
    parameter int DIV = 250000
) (
    input  logic Clk_100M,
    input  logic Rst_n,
    output logic tick_en
);

    localparam int W = cnt_width(DIV - 1);

    logic [W-1:0] cnt;
    logic         at_top;

    assign at_top = (cnt == W'(DIV - 1));

    always_ff @(posedge Clk_100M) begin
        if (!Rst_n) begin
            cnt     <= '0;
            tick_en <= 1'b0;
        end else begin
            tick_en <= at_top;
            cnt     <= at_top ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button conditioner: shared prescaler, per-channel sync + debounce FSM.
// Optional auto-repeat output btn_rpt is built when DEBOUNCE_REPEAT_EN is defined.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_STABLE | synchronised input equals btn_level; window count held at 0
//   ST_PEND   | input differs from btn_level; counting ticks toward accept
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int CLK_HZ        = 100_000_000,
    parameter int TICK_HZ       = 400,
    parameter int STABLE_TICKS  = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW_IN = 0
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int RPT_DELAY     = 200,
    parameter int RPT_PERIOD    = 40
`endif
) (
    input  logic            Clk_100M,
    input  logic            Rst_n,
    input  logic [N_CH-1:0] btn_raw,
    output logic            tick_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall
`ifdef DEBOUNCE_REPEAT_EN
    ,
    output logic [N_CH-1:0] btn_rpt
`endif
);

    localparam int DIV = div_calc(CLK_HZ, TICK_HZ);
    localparam int CW  = cnt_width(STABLE_TICKS);
`ifdef DEBOUNCE_REPEAT_EN
    localparam int RW  = cnt_width(max2(RPT_DELAY, RPT_PERIOD));
`endif

    logic [N_CH-1:0]                  pin_sense;
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;

    tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .Clk_100M(Clk_100M),
        .Rst_n   (Rst_n),
        .tick_en (tick_en)
    );

    // Polarity is normalised before the synchroniser so every stage sees pressed = 1.
    assign pin_sense = (ACTIVE_LOW_IN != 0) ? ~btn_raw : btn_raw;

    always_ff @(posedge Clk_100M) begin
        if (!Rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_sense};
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        db_state_t     state;
        logic [CW-1:0] cnt_ch;
        logic          level_q;
        logic          rise_q;
        logic          fall_q;
        logic          s;
        logic          accept;

        assign s      = sync_q[SYNC_STAGES-1][i];
        // A bounce back in the same cycle as the tick wins: s != level_q is required.
        assign accept = (state == ST_PEND) && (s != level_q) && tick_en
                        && (cnt_ch == CW'(STABLE_TICKS - 1));

        always_ff @(posedge Clk_100M) begin
            if (!Rst_n) begin
                state   <= ST_STABLE;
                cnt_ch  <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                case (state)
                    ST_STABLE: begin
                        cnt_ch <= '0;
                        if (s != level_q) begin
                            state <= ST_PEND;
                        end
                    end
                    ST_PEND: begin
                        if (s == level_q) begin
                            state  <= ST_STABLE;
                            cnt_ch <= '0;
                        end else if (accept) begin
                            level_q <= s;
                            rise_q  <= s;
                            fall_q  <= ~s;
                            cnt_ch  <= '0;
                            state   <= ST_STABLE;
                        end else if (tick_en) begin
                            cnt_ch <= cnt_ch + 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_STABLE;
                        cnt_ch <= '0;
                    end
                endcase
            end
        end

        assign btn_level[i] = level_q;
        assign btn_rise[i]  = rise_q;
        assign btn_fall[i]  = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
        logic [RW-1:0] rpt_cnt;
        logic          rpt_q;

        // Down-counter reloaded while released; the accepting tick of a release never repeats.
        always_ff @(posedge Clk_100M) begin
            if (!Rst_n) begin
                rpt_cnt <= RW'(RPT_DELAY - 1);
                rpt_q   <= 1'b0;
            end else begin
                rpt_q <= 1'b0;
                if (!level_q || accept) begin
                    rpt_cnt <= RW'(RPT_DELAY - 1);
                end else if (tick_en) begin
                    if (rpt_cnt == '0) begin
                        rpt_q   <= 1'b1;
                        rpt_cnt <= RW'(RPT_PERIOD - 1);
                    end else begin
                        rpt_cnt <= rpt_cnt - 1'b1;
                    end
                end
            end
        end

        assign btn_rpt[i] = rpt_q;
`endif
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with DIV=10, STABLE_TICKS=3, SYNC_STAGES=2.
// Repeat checks are compiled in when DEBOUNCE_REPEAT_EN is defined.
module tb_debounce_bank;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw;
    logic [3:0] raw_inv;
    logic       tick_en, tick_inv;
    logic [3:0] btn_level, btn_rise, btn_fall;
    logic [3:0] level_inv, rise_inv, fall_inv;
`ifdef DEBOUNCE_REPEAT_EN
    logic [3:0] btn_rpt, rpt_inv;
`endif

    int total = 0;
    int bad   = 0;

    debounce_bank #(
        .N_CH(4), .CLK_HZ(1000), .TICK_HZ(100), .STABLE_TICKS(3),
        .SYNC_STAGES(2), .ACTIVE_LOW_IN(0)
`ifdef DEBOUNCE_REPEAT_EN
        , .RPT_DELAY(5), .RPT_PERIOD(2)
`endif
    ) dut (
        .Clk_100M (clk),
        .Rst_n    (rst_n),
        .btn_raw  (raw),
        .tick_en  (tick_en),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
`ifdef DEBOUNCE_REPEAT_EN
        , .btn_rpt(btn_rpt)
`endif
    );

    debounce_bank #(
        .N_CH(4), .CLK_HZ(1000), .TICK_HZ(100), .STABLE_TICKS(3),
        .SYNC_STAGES(2), .ACTIVE_LOW_IN(1)
`ifdef DEBOUNCE_REPEAT_EN
        , .RPT_DELAY(5), .RPT_PERIOD(2)
`endif
    ) dut_inv (
        .Clk_100M (clk),
        .Rst_n    (rst_n),
        .btn_raw  (raw_inv),
        .tick_en  (tick_inv),
        .btn_level(level_inv),
        .btn_rise (rise_inv),
        .btn_fall (fall_inv)
`ifdef DEBOUNCE_REPEAT_EN
        , .btn_rpt(rpt_inv)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int rise_cnt[4];
    int fall_cnt[4];

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < 4; c++) begin
            if (btn_rise[c]) rise_cnt[c]++;
            if (btn_fall[c]) fall_cnt[c]++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Leaves us on the negedge right after the edge that raised tick_en.
    task automatic wait_tick();
        int n = 0;
        while (tick_en !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        check("tick_wait", {31'd0, tick_en}, 32'd1);
    endtask

    typedef struct {
        bit         align;
        logic [3:0] raw;
        int         adv;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vecs[11];
    int   r0[4];
    int   f0[4];

    initial begin
        // Each vector: optionally align to a tick, drive raw, advance, then compare.
        vecs[0]  = '{1'b1, 4'b0001, 30, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b0, 4'b0001,  1, 4'b0001, 4'b0001, 4'b0000};
        vecs[2]  = '{1'b0, 4'b0001,  1, 4'b0001, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b1, 4'b0000, 30, 4'b0001, 4'b0000, 4'b0000};
        vecs[4]  = '{1'b0, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0001};
        vecs[5]  = '{1'b1, 4'b0101, 30, 4'b0000, 4'b0000, 4'b0000};
        vecs[6]  = '{1'b0, 4'b0101,  1, 4'b0101, 4'b0101, 4'b0000};
        vecs[7]  = '{1'b0, 4'b0101,  1, 4'b0101, 4'b0000, 4'b0000};
        vecs[8]  = '{1'b1, 4'b0100, 30, 4'b0101, 4'b0000, 4'b0000};
        vecs[9]  = '{1'b0, 4'b0100,  1, 4'b0100, 4'b0000, 4'b0001};
        vecs[10] = '{1'b0, 4'b0100,  1, 4'b0100, 4'b0000, 4'b0000};

        rst_n   = 1'b0;
        raw     = 4'b0000;
        raw_inv = 4'b1111;
        step(3);
        check("rst_level", btn_level, 0);
        check("rst_rise", btn_rise, 0);
        check("rst_fall", btn_fall, 0);
        check("rst_tick", tick_en, 0);

        // Prescaler cadence after release.
        rst_n = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            step(1);
            check($sformatf("tick_k%0d", k), tick_en, (k % 10 == 0));
            check($sformatf("tick_inv_k%0d", k), tick_inv, (k % 10 == 0));
        end
        check("idle_level", btn_level, 0);
        check("idle_level_inv", level_inv, 0);

        r0 = rise_cnt;
        f0 = fall_cnt;
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].align) wait_tick();
            raw = vecs[i].raw;
            step(vecs[i].adv);
            check($sformatf("vec%0d_level", i), btn_level, vecs[i].lvl);
            check($sformatf("vec%0d_rise", i), btn_rise, vecs[i].rise);
            check($sformatf("vec%0d_fall", i), btn_fall, vecs[i].fall);
        end
        check("rise0_count", rise_cnt[0] - r0[0], 2);
        check("fall0_count", fall_cnt[0] - f0[0], 2);
        check("rise2_count", rise_cnt[2] - r0[2], 1);
        check("fall2_count", fall_cnt[2] - f0[2], 0);
        check("rise1_count", rise_cnt[1] - r0[1], 0);
        check("rise3_count", rise_cnt[3] - r0[3], 0);
        check("inv_quiet_level", level_inv, 0);
        check("inv_quiet_fall", fall_inv, 0);

        // Bounce on ch1: the window restarts after the input settles again.
        r0 = rise_cnt;
        wait_tick();
        raw = 4'b0110;
        step(10);
        raw = 4'b0100;
        step(10);
        raw = 4'b0110;
        step(30);
        check("bounce_level_early", btn_level, 4'b0100);
        check("bounce_no_rise", rise_cnt[1] - r0[1], 0);
        step(1);
        check("bounce_level", btn_level, 4'b0110);
        check("bounce_rise", btn_rise, 4'b0010);

        // ch3 returns to idle in the very cycle the accepting tick arrives.
        r0 = rise_cnt;
        wait_tick();
        raw = 4'b1110;
        step(28);
        raw = 4'b0110;
        step(12);
        check("simul_level", btn_level, 4'b0110);
        check("simul_no_rise", rise_cnt[3] - r0[3], 0);

        // Reset after two counted ticks discards the partial window.
        wait_tick();
        raw = 4'b0111;
        step(25);
        rst_n = 1'b0;
        step(1);
        check("midrst_level", btn_level, 0);
        check("midrst_tick", tick_en, 0);
        check("midrst_rise", btn_rise, 0);
        rst_n = 1'b1;
        step(10);
        check("postrst_tick", tick_en, 1);
        step(20);
        check("postrst_level_early", btn_level, 0);
        step(1);
        check("postrst_level", btn_level, 4'b0111);
        check("postrst_rise", btn_rise, 4'b0111);
        step(1);
        check("postrst_rise_gone", btn_rise, 0);

        // Active-low instance: pin 0 means pressed.
        wait_tick();
        raw_inv = 4'b0111;
        step(30);
        check("inv_level_early", level_inv, 0);
        step(1);
        check("inv_level", level_inv, 4'b1000);
        check("inv_rise", rise_inv, 4'b1000);
        check("main_unaffected", btn_level, 4'b0111);

`ifdef DEBOUNCE_REPEAT_EN
        wait_tick();
        raw = 4'b1111;
        step(31);
        check("rpt_rise", btn_rise[3], 1);
        check("rpt_not_on_rise", btn_rpt[3], 0);
        for (int q = 1; q <= 160; q++) begin
            step(1);
            check($sformatf("rpt_q%0d", q), btn_rpt[3], (q == 50 || q == 70 || q == 90));
            if (q == 71) raw = 4'b0111;
            if (q == 100) begin
                check("rpt_release_level", btn_level[3], 0);
                check("rpt_release_fall", btn_fall[3], 1);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
